demux_4_tdm: RTL and testbench



---
 rtl/demux_4_tdm.sv | 106 ++++++++++
 tb/tb_demux_4_tdm.sv | 131 +++++++++++++
 2 files changed

// File: rtl/demux_4_tdm.sv
// Time-division 1:4 demultiplexer: tracks the slot index of a serial stream with
// four slots per frame and presents each complete frame as parallel registered outputs.
module demux_4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             s1,
  output logic             s0,
  output logic             frame_valid,
  output logic             frame_err
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state, state_next;
  logic [1:0]       cnt, cnt_next;
  logic             fv_next, fe_next;
  logic             load_sh0, load_sh1, load_sh2, load_y;
  logic [WIDTH-1:0] sh0, sh1, sh2;

  assign s1 = cnt[1];
  assign s0 = cnt[0];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    fv_next    = 1'b0;
    fe_next    = 1'b0;
    load_sh0   = 1'b0;
    load_sh1   = 1'b0;
    load_sh2   = 1'b0;
    load_y     = 1'b0;
    if (din_valid) begin
      case (state)
        IDLE: begin
          if (sof) begin
            load_sh0   = 1'b1;
            cnt_next   = 2'd1;
            state_next = COLLECT;
          end
        end
        COLLECT: begin
          // sof always restarts the frame, even in the slot-3 position
          if (sof) begin
            fe_next  = 1'b1;
            load_sh0 = 1'b1;
            cnt_next = 2'd1;
          end else if (cnt == 2'd3) begin
            load_y     = 1'b1;
            fv_next    = 1'b1;
            cnt_next   = 2'd0;
            state_next = IDLE;
          end else begin
            load_sh1 = (cnt == 2'd1);
            load_sh2 = (cnt == 2'd2);
            cnt_next = cnt + 2'd1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      frame_valid <= fv_next;
      frame_err   <= fe_next;
      if (load_y) begin
        y0 <= sh0;
        y1 <= sh1;
        y2 <= sh2;
        y3 <= din;
      end
    end
  end

  // Shadow slots are always written before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load_sh0) sh0 <= din;
    if (load_sh1) sh1 <= din;
    if (load_sh2) sh2 <= din;
  end

endmodule

// File: tb/tb_demux_4_tdm.sv
// Directed bench for demux_4_tdm: linear stimulus with hand-computed expected outputs.
module tb_demux_4_tdm;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sof;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic             s1, s0, frame_valid, frame_err;

  int checks = 0;
  int errors = 0;

  demux_4_tdm #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .s1(s1), .s0(s0), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Apply one cycle of input, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic f, input logic [WIDTH-1:0] d);
    din_valid = v;
    sof       = f;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                         input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3,
                         input logic [1:0] es, input logic efv, input logic efe);
    check({tag, "_y0"}, 32'(y0), 32'(e0));
    check({tag, "_y1"}, 32'(y1), 32'(e1));
    check({tag, "_y2"}, 32'(y2), 32'(e2));
    check({tag, "_y3"}, 32'(y3), 32'(e3));
    check({tag, "_sel"}, 32'({s1, s0}), 32'(es));
    check({tag, "_fv"}, 32'(frame_valid), 32'(efv));
    check({tag, "_fe"}, 32'(frame_err), 32'(efe));
  endtask

  initial begin
    rst = 1'b1;
    din_valid = 1'b0;
    sof = 1'b0;
    din = '0;
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hF);
    chk_all("reset", 0, 0, 0, 0, 2'b00, 0, 0);
    rst = 1'b0;

    // Basic frame 1,0,1,0
    step(1, 1, 4'h1); chk_all("f1_s0", 0, 0, 0, 0, 2'b01, 0, 0);
    step(1, 0, 4'h0); chk_all("f1_s1", 0, 0, 0, 0, 2'b10, 0, 0);
    step(1, 0, 4'h1); chk_all("f1_s2", 0, 0, 0, 0, 2'b11, 0, 0);
    step(1, 0, 4'h0); chk_all("f1_s3", 1, 0, 1, 0, 2'b00, 1, 0);
    step(0, 0, 4'h0); chk_all("f1_after", 1, 0, 1, 0, 2'b00, 0, 0);

    // Same frame with a two-cycle gap between slots 1 and 2
    step(1, 1, 4'h1); chk_all("gap_s0", 1, 0, 1, 0, 2'b01, 0, 0);
    step(1, 0, 4'h0); chk_all("gap_s1", 1, 0, 1, 0, 2'b10, 0, 0);
    step(0, 0, 4'h7); chk_all("gap_h1", 1, 0, 1, 0, 2'b10, 0, 0);
    step(0, 1, 4'h7); chk_all("gap_h2", 1, 0, 1, 0, 2'b10, 0, 0);
    step(1, 0, 4'h1); chk_all("gap_s2", 1, 0, 1, 0, 2'b11, 0, 0);
    step(1, 0, 4'h0); chk_all("gap_s3", 1, 0, 1, 0, 2'b00, 1, 0);

    // Early sof after two slots, new frame 1,1,0,0
    step(1, 1, 4'h0); chk_all("es_a0", 1, 0, 1, 0, 2'b01, 0, 0);
    step(1, 0, 4'h1); chk_all("es_a1", 1, 0, 1, 0, 2'b10, 0, 0);
    step(1, 1, 4'h1); chk_all("es_sof", 1, 0, 1, 0, 2'b01, 0, 1);
    step(1, 0, 4'h1); chk_all("es_b1", 1, 0, 1, 0, 2'b10, 0, 0);
    step(1, 0, 4'h0); chk_all("es_b2", 1, 0, 1, 0, 2'b11, 0, 0);
    step(1, 0, 4'h0); chk_all("es_b3", 1, 1, 0, 0, 2'b00, 1, 0);

    // sof in the slot-3 position is an early sof, not a completion
    step(1, 1, 4'h9); chk_all("s3sof_a0", 1, 1, 0, 0, 2'b01, 0, 0);
    step(1, 0, 4'h9); chk_all("s3sof_a1", 1, 1, 0, 0, 2'b10, 0, 0);
    step(1, 0, 4'h9); chk_all("s3sof_a2", 1, 1, 0, 0, 2'b11, 0, 0);
    step(1, 1, 4'h5); chk_all("s3sof_sof", 1, 1, 0, 0, 2'b01, 0, 1);
    step(1, 0, 4'h6); chk_all("s3sof_b1", 1, 1, 0, 0, 2'b10, 0, 0);
    step(1, 0, 4'h7); chk_all("s3sof_b2", 1, 1, 0, 0, 2'b11, 0, 0);
    step(1, 0, 4'h8); chk_all("s3sof_b3", 5, 6, 7, 8, 2'b00, 1, 0);

    // Valid samples without sof in IDLE are dropped
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'h1); chk_all("idle_drop", 5, 6, 7, 8, 2'b00, 0, 0);
    end

    // Reset mid-frame (after slot 2), with din_valid high in the reset cycle
    step(1, 1, 4'h0); chk_all("rm_s0", 5, 6, 7, 8, 2'b01, 0, 0);
    step(1, 0, 4'h1); chk_all("rm_s1", 5, 6, 7, 8, 2'b10, 0, 0);
    step(1, 0, 4'h1); chk_all("rm_s2", 5, 6, 7, 8, 2'b11, 0, 0);
    rst = 1'b1;
    step(1, 0, 4'hE); chk_all("rm_rst", 0, 0, 0, 0, 2'b00, 0, 0);
    rst = 1'b0;
    step(1, 0, 4'h3); chk_all("rm_nosof", 0, 0, 0, 0, 2'b00, 0, 0);
    step(1, 1, 4'h0); chk_all("rm_f0", 0, 0, 0, 0, 2'b01, 0, 0);
    step(1, 0, 4'h1); chk_all("rm_f1", 0, 0, 0, 0, 2'b10, 0, 0);
    step(1, 0, 4'h1); chk_all("rm_f2", 0, 0, 0, 0, 2'b11, 0, 0);
    step(1, 0, 4'h0); chk_all("rm_f3", 0, 1, 1, 0, 2'b00, 1, 0);

    // Back-to-back frames A,B,C,D then E,F,0,1
    step(1, 1, 4'hA); chk_all("bb_1", 0, 1, 1, 0, 2'b01, 0, 0);
    step(1, 0, 4'hB); chk_all("bb_2", 0, 1, 1, 0, 2'b10, 0, 0);
    step(1, 0, 4'hC); chk_all("bb_3", 0, 1, 1, 0, 2'b11, 0, 0);
    step(1, 0, 4'hD); chk_all("bb_4", 4'hA, 4'hB, 4'hC, 4'hD, 2'b00, 1, 0);
    step(1, 1, 4'hE); chk_all("bb_5", 4'hA, 4'hB, 4'hC, 4'hD, 2'b01, 0, 0);
    step(1, 0, 4'hF); chk_all("bb_6", 4'hA, 4'hB, 4'hC, 4'hD, 2'b10, 0, 0);
    step(1, 0, 4'h0); chk_all("bb_7", 4'hA, 4'hB, 4'hC, 4'hD, 2'b11, 0, 0);
    step(1, 0, 4'h1); chk_all("bb_8", 4'hE, 4'hF, 4'h0, 4'h1, 2'b00, 1, 0);
    step(0, 0, 4'h0); chk_all("bb_end", 4'hE, 4'hF, 4'h0, 4'h1, 2'b00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
